pad_out_arbiter: RTL and testbench

PAD_OUT_ARBITER -- requirements
Module: pad_out_arbiter

---
 rtl/chip_pkg.sv | 28 ++
 rtl/bit_sync.sv | 25 ++
 rtl/pad_out_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_pad_out_arbiter.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chip_pkg.sv
// Shared definitions for the output-pad arbiter.
//   arb_state_t          : arbiter FSM states
//   strobe_bit / id_lsb  : pad-field offsets for any pad width / requester count
//   STROBE_BIT / ID_LSB  : the same offsets at the default 32-pad, 4-requester build
package chip_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DRIVE    = 2'd1,
        WAIT_LOW = 2'd2
    } arb_state_t;

    localparam int DEF_NUM_REQ         = 4;
    localparam int DEF_NUM_OUTPUT_PADS = 32;

    function automatic int strobe_bit(input int num_pads);
        return num_pads - 1;
    endfunction

    // The id field sits directly below the strobe; data fills everything beneath it.
    function automatic int id_lsb(input int num_pads, input int num_req);
        return num_pads - 1 - $clog2(num_req);
    endfunction

    localparam int STROBE_BIT = strobe_bit(DEF_NUM_OUTPUT_PADS);
    localparam int ID_LSB     = id_lsb(DEF_NUM_OUTPUT_PADS, DEF_NUM_REQ);

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchronizer for a single asynchronous level.
//   clk : destination clock
//   rst : synchronous active-high reset, clears both flops
//   d   : asynchronous input
//   q   : synchronized output (two clk edges of latency)
module bit_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pad_out_arbiter.sv
// Round-robin arbiter that lets NUM_REQ core requesters share one output pad bus
// using a four-phase strobe/ack handshake with an off-chip receiver.
//   clk, rst    : single clock, synchronous active-high reset
//   req_valid   : per-requester word valid
//   req_data    : per-requester word (DATA_W bits each)
//   req_last    : word is the last of its burst
//   req_ready   : one-hot, one-cycle word-accepted pulse (combinational)
//   ext_ack     : asynchronous off-chip acknowledge
//   err_clr     : clears the sticky timeout flag
//   pad_out     : {strobe, requester id, data}
//   busy        : FSM not idle
//   timeout_err : sticky flag, set when a handshake edge never arrives
module pad_out_arbiter
    import chip_pkg::*;
#(
    parameter  int NUM_REQ         = DEF_NUM_REQ,
    parameter  int NUM_OUTPUT_PADS = DEF_NUM_OUTPUT_PADS,
    parameter  int MAX_BURST       = 16,
    parameter  int TIMEOUT         = 1024,
    localparam int ID_W            = $clog2(NUM_REQ),
    localparam int DATA_W          = NUM_OUTPUT_PADS - 1 - ID_W
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]    req_data,
    input  logic [NUM_REQ-1:0]                req_last,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic                              ext_ack,
    input  logic                              err_clr,
    output logic [NUM_OUTPUT_PADS-1:0]        pad_out,
    output logic                              busy,
    output logic                              timeout_err
);

    localparam int STB     = strobe_bit(NUM_OUTPUT_PADS);
    localparam int IDL     = id_lsb(NUM_OUTPUT_PADS, NUM_REQ);
    localparam int BURST_W = $clog2(MAX_BURST + 1);
    localparam int TMO_W   = $clog2(TIMEOUT);

    arb_state_t                 state_q, state_nxt;
    logic [ID_W-1:0]            grant_q, grant_nxt;
    logic [ID_W-1:0]            last_grant_q, last_grant_nxt;
    logic [BURST_W-1:0]         burst_cnt_q, burst_cnt_nxt;
    logic [TMO_W-1:0]           tmo_cnt_q, tmo_cnt_nxt;
    logic                       last_q, last_nxt;
    logic                       err_q, err_nxt;
    logic [NUM_OUTPUT_PADS-1:0] pad_q, pad_nxt;
    logic [NUM_REQ-1:0]         ready_c;
    logic                       ack_s;
    logic                       pick_found;
    logic [ID_W-1:0]            pick_id;
    logic                       tmo_expired;
    logic                       burst_done;

    bit_sync u_ack_sync (
        .clk (clk),
        .rst (rst),
        .d   (ext_ack),
        .q   (ack_s)
    );

    // First valid requester after the previous grant, wrapping around.
    // Scanning from the far end lets the nearest candidate overwrite the result.
    function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                              input logic [ID_W-1:0]    last);
        logic [ID_W:0] res;
        int            idx;
        res = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = (int'(last) + i) % NUM_REQ;
            if (valid[idx]) begin
                res = {1'b1, idx[ID_W-1:0]};
            end
        end
        return res;
    endfunction

    function automatic logic [NUM_OUTPUT_PADS-1:0] pad_word(input logic [ID_W-1:0]   id,
                                                            input logic [DATA_W-1:0] data);
        logic [NUM_OUTPUT_PADS-1:0] w;
        w            = '0;
        w[STB]       = 1'b1;
        w[STB-1:IDL] = id;
        w[IDL-1:0]   = data;
        return w;
    endfunction

    assign {pick_found, pick_id} = rr_pick(req_valid, last_grant_q);
    assign tmo_expired = (tmo_cnt_q == TMO_W'(TIMEOUT - 1));
    assign burst_done  = last_q || (burst_cnt_q == BURST_W'(MAX_BURST));

    always_comb begin
        state_nxt      = state_q;
        grant_nxt      = grant_q;
        last_grant_nxt = last_grant_q;
        burst_cnt_nxt  = burst_cnt_q;
        tmo_cnt_nxt    = tmo_cnt_q;
        last_nxt       = last_q;
        pad_nxt        = pad_q;
        ready_c        = '0;
        // A timeout raised below overrides this clear in the same cycle.
        err_nxt        = err_q & ~err_clr;

        case (state_q)
            IDLE: begin
                // Holding off while ack_s is still high keeps a late ack from a
                // timed-out transfer from completing the next one.
                if (pick_found && !ack_s) begin
                    ready_c[pick_id] = 1'b1;
                    grant_nxt        = pick_id;
                    last_grant_nxt   = pick_id;
                    pad_nxt          = pad_word(pick_id, req_data[pick_id]);
                    last_nxt         = req_last[pick_id];
                    burst_cnt_nxt    = BURST_W'(1);
                    tmo_cnt_nxt      = '0;
                    state_nxt        = DRIVE;
                end
            end

            DRIVE: begin
                if (ack_s) begin
                    pad_nxt[STB] = 1'b0;
                    tmo_cnt_nxt  = '0;
                    state_nxt    = WAIT_LOW;
                end else if (tmo_expired) begin
                    pad_nxt[STB] = 1'b0;
                    err_nxt      = 1'b1;
                    state_nxt    = IDLE;
                end else begin
                    tmo_cnt_nxt = tmo_cnt_q + 1'b1;
                end
            end

            WAIT_LOW: begin
                if (!ack_s) begin
                    if (burst_done) begin
                        state_nxt = IDLE;
                    end else if (req_valid[grant_q]) begin
                        ready_c[grant_q] = 1'b1;
                        pad_nxt          = pad_word(grant_q, req_data[grant_q]);
                        last_nxt         = req_last[grant_q];
                        burst_cnt_nxt    = burst_cnt_q + 1'b1;
                        tmo_cnt_nxt      = '0;
                        state_nxt        = DRIVE;
                    end else begin
                        // Requester stalled: give the bus back rather than wait.
                        state_nxt = IDLE;
                    end
                end else if (tmo_expired) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    tmo_cnt_nxt = tmo_cnt_q + 1'b1;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            burst_cnt_q  <= '0;
            tmo_cnt_q    <= '0;
            last_q       <= 1'b0;
            err_q        <= 1'b0;
            pad_q        <= '0;
        end else begin
            state_q      <= state_nxt;
            grant_q      <= grant_nxt;
            last_grant_q <= last_grant_nxt;
            burst_cnt_q  <= burst_cnt_nxt;
            tmo_cnt_q    <= tmo_cnt_nxt;
            last_q       <= last_nxt;
            err_q        <= err_nxt;
            pad_q        <= pad_nxt;
        end
    end

    // Gated by rst so no word is reported accepted while the capture is discarded.
    assign req_ready   = ready_c & {NUM_REQ{~rst}};
    assign pad_out     = pad_q;
    assign busy        = (state_q != IDLE);
    assign timeout_err = err_q;

endmodule

// File: tb/tb_pad_out_arbiter.sv
module tb_pad_out_arbiter;
    import chip_pkg::*;

    localparam int NREQ = 4;
    localparam int DW   = 29;
    localparam int TMO  = 8;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NREQ-1:0]          req_valid;
    logic [NREQ-1:0][DW-1:0]  req_data;
    logic [NREQ-1:0]          req_last;
    logic [NREQ-1:0]          req_ready;
    logic                     ext_ack;
    logic                     err_clr;
    logic [31:0]              pad_out;
    logic                     busy;
    logic                     timeout_err;

    always #5 clk = ~clk;

    pad_out_arbiter #(
        .NUM_REQ(NREQ), .NUM_OUTPUT_PADS(32), .MAX_BURST(16), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .ext_ack(ext_ack),
        .err_clr(err_clr), .pad_out(pad_out), .busy(busy), .timeout_err(timeout_err)
    );

    int checks = 0;
    int errors = 0;

    // Requester sources, observed transfers and responder state.
    logic [DW-1:0]   src_data [NREQ][$];
    bit              src_last [NREQ][$];
    int              obs_id [$];
    logic [DW-1:0]   obs_data [$];
    bit              strobe_prev;
    bit              resp_en;
    int              ack_wait;
    int              ack_max;
    logic [NREQ-1:0] rdy_last;
    int              ready_pulses;
    bit              multi_rdy;

    function automatic logic [31:0] exp_pad(input int id, input logic [DW-1:0] d, input logic stb);
        logic [1:0] i2;
        i2 = id[1:0];
        return {stb, i2, d};
    endfunction

    task automatic drive_sources();
        for (int i = 0; i < NREQ; i++) begin
            if (src_data[i].size() > 0) begin
                req_valid[i] = 1'b1;
                req_data[i]  = src_data[i][0];
                req_last[i]  = src_last[i][0];
            end else begin
                req_valid[i] = 1'b0;
                req_data[i]  = '0;
                req_last[i]  = 1'b0;
            end
        end
    endtask

    task automatic push_word(input int r, input logic [DW-1:0] d, input bit l);
        src_data[r].push_back(d);
        src_last[r].push_back(l);
    endtask

    // One clock: sample ready mid-cycle, then after the edge pop accepted words,
    // record new strobes and let the ack responder react.
    task automatic run_cycle();
        logic [NREQ-1:0] r;
        @(negedge clk);
        r = req_ready;
        @(posedge clk);
        #1;
        rdy_last = r;
        ready_pulses += $countones(r);
        if ($countones(r) > 1) multi_rdy = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            if (r[i] && src_data[i].size() > 0) begin
                void'(src_data[i].pop_front());
                void'(src_last[i].pop_front());
            end
        end
        drive_sources();
        if (pad_out[STROBE_BIT] && !strobe_prev) begin
            obs_id.push_back(int'(pad_out[STROBE_BIT-1:ID_LSB]));
            obs_data.push_back(pad_out[ID_LSB-1:0]);
        end
        strobe_prev = pad_out[STROBE_BIT];
        if (resp_en && (pad_out[STROBE_BIT] != ext_ack)) begin
            if (ack_wait == 0) begin
                ext_ack  = pad_out[STROBE_BIT];
                ack_wait = $urandom_range(0, ack_max);
            end else begin
                ack_wait--;
            end
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1; ext_ack = 1'b0; err_clr = 1'b0; resp_en = 1'b0;
        ack_wait = 0; ack_max = 1;
        for (int i = 0; i < NREQ; i++) begin
            src_data[i].delete();
            src_last[i].delete();
        end
        drive_sources();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        obs_id.delete(); obs_data.delete();
        strobe_prev = 1'b0; ready_pulses = 0; multi_rdy = 1'b0; rdy_last = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; ext_ack = 1'b0; err_clr = 1'b0;
        req_valid = '1; req_data = '1; req_last = '1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (pad_out !== 32'h0) begin errors++; $display("FAIL reset_pad: got %h expected %h", pad_out, 32'h0); end
        checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", timeout_err); end
        apply_reset();
    endtask

    task automatic test_single_word();
        logic [DW-1:0] d;
        int n;
        d = 29'h1ABCDEF;
        apply_reset();
        push_word(2, d, 1'b1);
        drive_sources();
        run_cycle();
        checks++; if (rdy_last !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b expected 0100", rdy_last); end
        checks++; if (pad_out !== exp_pad(2, d, 1'b1)) begin errors++; $display("FAIL single_pad: got %h expected %h", pad_out, exp_pad(2, d, 1'b1)); end
        repeat (3) run_cycle();
        checks++; if (pad_out !== exp_pad(2, d, 1'b1)) begin errors++; $display("FAIL single_hold: got %h expected %h", pad_out, exp_pad(2, d, 1'b1)); end
        ext_ack = 1'b1;
        n = 0;
        while (pad_out[STROBE_BIT] && n < 10) begin run_cycle(); n++; end
        // two synchronizer edges, then one FSM edge
        checks++; if (n != 3) begin errors++; $display("FAIL single_strobe_fall: got %0d edges expected 3", n); end
        ext_ack = 1'b0;
        n = 0;
        while (busy && n < 10) begin run_cycle(); n++; end
        checks++; if (n != 3) begin errors++; $display("FAIL single_idle: got %0d edges expected 3", n); end
        checks++; if (pad_out !== exp_pad(2, d, 1'b0)) begin errors++; $display("FAIL single_idle_pad: got %h expected %h", pad_out, exp_pad(2, d, 1'b0)); end
        checks++; if (ready_pulses != 1) begin errors++; $display("FAIL single_ready_count: got %0d expected 1", ready_pulses); end
    endtask

    task automatic test_contention();
        int cyc;
        int exp_order[5] = '{0, 1, 2, 3, 0};
        apply_reset();
        resp_en = 1'b1; ack_max = 1;
        for (int r = 0; r < NREQ; r++) begin
            push_word(r, DW'(32'h10 * r + 1), 1'b1);
            push_word(r, DW'(32'h10 * r + 2), 1'b1);
        end
        drive_sources();
        cyc = 0;
        while (obs_id.size() < 5 && cyc < 300) begin run_cycle(); cyc++; end
        checks++;
        if (obs_id.size() < 5) begin
            errors++; $display("FAIL contention_progress: got %0d words expected 5", obs_id.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (obs_id[k] != exp_order[k]) begin errors++; $display("FAIL contention_order[%0d]: got %0d expected %0d", k, obs_id[k], exp_order[k]); end
            end
        end
    endtask

    task automatic test_burst_limit();
        int cyc;
        apply_reset();
        resp_en = 1'b1; ack_max = 1;
        for (int k = 0; k < 20; k++) push_word(1, DW'(32'h100 + k), 1'b0);
        push_word(2, DW'(32'h2222), 1'b1);
        drive_sources();
        cyc = 0;
        while (obs_id.size() < 17 && cyc < 800) begin run_cycle(); cyc++; end
        checks++;
        if (obs_id.size() < 17) begin
            errors++; $display("FAIL burst_progress: got %0d words expected 17", obs_id.size());
        end else begin
            for (int k = 0; k < 16; k++) begin
                checks++;
                if (obs_id[k] != 1 || obs_data[k] !== DW'(32'h100 + k)) begin
                    errors++; $display("FAIL burst_word[%0d]: got id %0d data %h expected id 1 data %h", k, obs_id[k], obs_data[k], DW'(32'h100 + k));
                end
            end
            checks++;
            if (obs_id[16] != 2) begin errors++; $display("FAIL burst_handover: got id %0d expected 2", obs_id[16]); end
        end
    endtask

    task automatic test_timeout();
        int n;
        int idle_pulses;
        apply_reset();
        push_word(0, DW'(32'h55), 1'b1);
        drive_sources();
        run_cycle();
        n = 0;
        while (pad_out[STROBE_BIT] && n < 20) begin run_cycle(); n++; end
        checks++; if (n != TMO) begin errors++; $display("FAIL timeout_fall: got %0d edges expected %0d", n, TMO); end
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_err_set: got %b expected 1", timeout_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy: got %b expected 0", busy); end
        err_clr = 1'b1; run_cycle(); err_clr = 1'b0;
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_err_clr: got %b expected 0", timeout_err); end
        // clear and set on the same edge: the new timeout must stick
        push_word(0, DW'(32'h66), 1'b1);
        drive_sources();
        run_cycle();
        repeat (TMO - 1) run_cycle();
        err_clr = 1'b1; run_cycle(); err_clr = 1'b0;
        checks++; if (timeout_err !== 1'b1 || pad_out[STROBE_BIT] !== 1'b0) begin
            errors++; $display("FAIL timeout_set_wins: got err %b strobe %b expected err 1 strobe 0", timeout_err, pad_out[STROBE_BIT]);
        end
        // ack stuck high: WAIT_LOW times out and arbitration holds off until ack drops
        apply_reset();
        push_word(0, DW'(32'h77), 1'b1);
        push_word(1, DW'(32'h88), 1'b1);
        drive_sources();
        run_cycle();
        ext_ack = 1'b1;
        n = 0;
        while ((busy || n == 0) && n < 40) begin run_cycle(); n++; end
        checks++; if (busy !== 1'b0 || timeout_err !== 1'b1) begin
            errors++; $display("FAIL ackhigh_timeout: got busy %b err %b expected busy 0 err 1", busy, timeout_err);
        end
        idle_pulses = ready_pulses;
        repeat (4) run_cycle();
        checks++; if (busy !== 1'b0 || ready_pulses != idle_pulses) begin
            errors++; $display("FAIL ackhigh_holdoff: got busy %b ready pulses %0d expected busy 0 pulses %0d", busy, ready_pulses, idle_pulses);
        end
        ext_ack = 1'b0;
        n = 0;
        while (obs_id.size() < 2 && n < 20) begin run_cycle(); n++; end
        checks++; if (obs_id.size() < 2 || obs_id[obs_id.size()-1] != 1) begin
            errors++; $display("FAIL ackhigh_resume: got %0d words expected requester 1 granted", obs_id.size());
        end
    endtask

    task automatic test_reset_mid_drive();
        int cyc;
        apply_reset();
        push_word(2, DW'(32'hA0A0), 1'b1);
        drive_sources();
        run_cycle();
        push_word(2, DW'(32'hB1B1), 1'b1);
        push_word(0, DW'(32'hC2C2), 1'b1);
        drive_sources();
        rst = 1'b1;
        run_cycle();
        checks++; if (pad_out !== 32'h0 || busy !== 1'b0 || timeout_err !== 1'b0) begin
            errors++; $display("FAIL rstmid_outputs: got pad %h busy %b err %b expected all 0", pad_out, busy, timeout_err);
        end
        checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL rstmid_ready: got %b expected 0000", req_ready); end
        rst = 1'b0;
        obs_id.delete(); obs_data.delete();
        resp_en = 1'b1; ack_max = 1;
        cyc = 0;
        while (obs_id.size() < 2 && cyc < 200) begin run_cycle(); cyc++; end
        checks++;
        if (obs_id.size() < 2) begin
            errors++; $display("FAIL rstmid_progress: got %0d words expected 2", obs_id.size());
        end else begin
            checks++; if (obs_id[0] != 0) begin errors++; $display("FAIL rstmid_first: got id %0d expected 0", obs_id[0]); end
            checks++; if (obs_id[1] != 2 || obs_data[1] !== DW'(32'hB1B1)) begin
                errors++; $display("FAIL rstmid_no_resend: got id %0d data %h expected id 2 data %h", obs_id[1], obs_data[1], DW'(32'hB1B1));
            end
        end
    endtask

    task automatic test_stall();
        int cyc;
        apply_reset();
        resp_en = 1'b1; ack_max = 1;
        // Requester 3 alone first so it owns the bus when it stalls.
        for (int i = 0; i < 3; i++) push_word(i, DW'(0), 1'b1);
        for (int i = 0; i < 3; i++) begin src_data[i].delete(); src_last[i].delete(); end
        push_word(3, DW'(32'h3A), 1'b0);
        drive_sources();
        cyc = 0;
        while ((obs_id.size() < 1 || busy) && cyc < 100) begin run_cycle(); cyc++; end
        checks++; if (obs_id.size() != 1 || busy !== 1'b0) begin
            errors++; $display("FAIL stall_release: got %0d words busy %b expected 1 word busy 0", obs_id.size(), busy);
        end
        push_word(3, DW'(32'h3B), 1'b1);
        push_word(0, DW'(32'h0C), 1'b1);
        drive_sources();
        cyc = 0;
        while (obs_id.size() < 3 && cyc < 200) begin run_cycle(); cyc++; end
        checks++;
        if (obs_id.size() < 3) begin
            errors++; $display("FAIL stall_progress: got %0d words expected 3", obs_id.size());
        end else begin
            checks++; if (obs_id[1] != 0 || obs_id[2] != 3) begin
                errors++; $display("FAIL stall_next: got ids %0d,%0d expected 0,3", obs_id[1], obs_id[2]);
            end
        end
    endtask

    task automatic test_random(input int round);
        logic [DW-1:0] m_data [NREQ][$];
        bit            m_last [NREQ][$];
        int            exp_id [$];
        logic [DW-1:0] exp_data [$];
        logic [31:0]   rnd;
        int n, g, idx, last, cnt, cyc;
        bit l, pending;
        apply_reset();
        resp_en = 1'b1; ack_max = 2;
        for (int r = 0; r < NREQ; r++) begin
            n = (r == round % NREQ) ? 20 : $urandom_range(0, 20);
            for (int k = 0; k < n; k++) begin
                rnd = $urandom;
                l = (r == round % NREQ) ? 1'b0 : ($urandom_range(0, 3) == 0);
                push_word(r, rnd[DW-1:0], l);
                m_data[r].push_back(rnd[DW-1:0]);
                m_last[r].push_back(l);
            end
        end
        // Reference: round-robin from the previous owner; a burst ends on last,
        // after 16 words, or when the owner runs dry.
        last = NREQ - 1;
        forever begin
            g = -1;
            for (int i = 1; i <= NREQ; i++) begin
                idx = (last + i) % NREQ;
                if (g < 0 && m_data[idx].size() > 0) g = idx;
            end
            if (g < 0) break;
            cnt = 0;
            do begin
                exp_id.push_back(g);
                exp_data.push_back(m_data[g].pop_front());
                l = m_last[g].pop_front();
                cnt++;
            end while (!l && cnt < 16 && m_data[g].size() > 0);
            last = g;
        end
        drive_sources();
        cyc = 0;
        pending = 1'b1;
        while (pending && cyc < 6000) begin
            run_cycle();
            cyc++;
            pending = busy || (obs_id.size() < exp_id.size());
            for (int i = 0; i < NREQ; i++) if (src_data[i].size() > 0) pending = 1'b1;
        end
        checks++; if (pending) begin errors++; $display("FAIL random%0d_progress: got %0d words expected %0d", round, obs_id.size(), exp_id.size()); end
        checks++; if (obs_id.size() != exp_id.size()) begin
            errors++; $display("FAIL random%0d_count: got %0d expected %0d", round, obs_id.size(), exp_id.size());
        end else begin
            for (int k = 0; k < exp_id.size(); k++) begin
                checks++;
                if (obs_id[k] != exp_id[k] || obs_data[k] !== exp_data[k]) begin
                    errors++; $display("FAIL random%0d_word[%0d]: got id %0d data %h expected id %0d data %h", round, k, obs_id[k], obs_data[k], exp_id[k], exp_data[k]);
                end
            end
        end
        checks++; if (multi_rdy || timeout_err !== 1'b0) begin
            errors++; $display("FAIL random%0d_sanity: got multi_ready %0d err %b expected 0 0", round, multi_rdy, timeout_err);
        end
    endtask

    initial begin
        rst = 1'b1; ext_ack = 1'b0; err_clr = 1'b0;
        req_valid = '0; req_data = '0; req_last = '0;
        test_reset();
        test_single_word();
        test_contention();
        test_burst_limit();
        test_timeout();
        test_reset_mid_drive();
        test_stall();
        for (int r = 0; r < 3; r++) test_random(r);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
